// File: rtl/demux2_pkg.sv
// Shared types and default sizes for the 1:2 registered stream demultiplexer.
package demux2_pkg;

   typedef enum logic {
      DEST0 = 1'b0,
      DEST1 = 1'b1
   } dest_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 8;

endpackage : demux2_pkg

// File: rtl/demux2_stream_if.sv
// Handshake bundle for demux2_stream: one input stream with a destination bit and two output streams.
interface demux2_stream_if #(
   parameter int WIDTH = demux2_pkg::DEF_WIDTH
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;

   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out0_data;

   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out1_data;

   // The source/consumer side drives words in and readies back.
   modport master (
      output in_valid, in_data, in_sel, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out1_valid, out1_data
   );

   modport slave (
      input  in_valid, in_data, in_sel, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out1_valid, out1_data
   );

endinterface : demux2_stream_if

// File: rtl/demux2_stream_out_slot.sv
// One-entry holding register for a single demux output: a word plus its full flag.
module out_slot
   import demux2_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;

   // A load wins over a same-edge drain so the slot refills without a bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (load) begin
         r_full <= 1'b1;
         r_data <= load_data;
      end else if (r_full && ready) begin
         r_full <= 1'b0;
      end
   end

   assign valid = r_full;
   assign data  = r_data;

endmodule : out_slot

// File: rtl/demux2_stream.sv
// 1:2 registered stream demultiplexer with per-output delivered-word counters.
module demux2_stream
   import demux2_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   demux2_stream_if.slave   bus,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   dest_t            w_sel;
   logic             w_valid0;
   logic             w_valid1;
   logic [WIDTH-1:0] w_data0;
   logic [WIDTH-1:0] w_data1;
   logic             w_selFull;
   logic             w_selReady;
   logic             w_inReady;
   logic             w_inXfer;
   logic             w_load0;
   logic             w_load1;
   logic             w_out0Xfer;
   logic             w_out1Xfer;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   // Readiness looks only at the selected slot, so a stalled output never blocks the other one.
   always_comb begin
      w_sel      = dest_t'(bus.in_sel);
      w_selFull  = (w_sel == DEST1) ? w_valid1 : w_valid0;
      w_selReady = (w_sel == DEST1) ? bus.out1_ready : bus.out0_ready;
      w_inReady  = !w_selFull || w_selReady;
      w_inXfer   = bus.in_valid && w_inReady;
      w_load0    = w_inXfer && (w_sel == DEST0);
      w_load1    = w_inXfer && (w_sel == DEST1);
      w_out0Xfer = w_valid0 && bus.out0_ready;
      w_out1Xfer = w_valid1 && bus.out1_ready;
   end

   out_slot #(.WIDTH(WIDTH)) u_slot0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (w_load0),
      .load_data (bus.in_data),
      .ready     (bus.out0_ready),
      .valid     (w_valid0),
      .data      (w_data0)
   );

   out_slot #(.WIDTH(WIDTH)) u_slot1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (w_load1),
      .load_data (bus.in_data),
      .ready     (bus.out1_ready),
      .valid     (w_valid1),
      .data      (w_data1)
   );

   // Clear outranks a same-edge increment; counters wrap freely.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (cnt_clr) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_out0Xfer) r_cnt0 <= r_cnt0 + CNT_W'(1);
         if (w_out1Xfer) r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
   end

   assign bus.in_ready   = w_inReady;
   assign bus.out0_valid = w_valid0;
   assign bus.out0_data  = w_data0;
   assign bus.out1_valid = w_valid1;
   assign bus.out1_data  = w_data1;
   assign cnt0           = r_cnt0;
   assign cnt1           = r_cnt1;

endmodule : demux2_stream

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: queue-based reference model plus directed literal checks.
module tb_demux2_stream;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
   localparam int CNT_MOD = 1 << CNT_W;

   logic             clk;
   logic             reset_n;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;
   int               checks;
   int               errors;

   demux2_stream_if #(.WIDTH(WIDTH)) bus ();

   demux2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave),
      .cnt_clr (cnt_clr),
      .cnt0    (cnt0),
      .cnt1    (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against an expected one and tally the result.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's worth of inputs and let combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                                input logic r0, input logic r1, input logic clr);
      bus.in_valid   = v;
      bus.in_sel     = sel;
      bus.in_data    = d;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
      cnt_clr        = clr;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: each output is a queue holding at most one word, counters are plain integers.
   logic [WIDTH-1:0] q0[$];
   logic [WIDTH-1:0] q1[$];
   int               mCnt0;
   int               mCnt1;

   function automatic logic modelInReady();
      logic full;
      logic rdy;
      full = bus.in_sel ? (q1.size() != 0) : (q0.size() != 0);
      rdy  = bus.in_sel ? bus.out1_ready : bus.out0_ready;
      return !full || rdy;
   endfunction

   always @(posedge clk or negedge reset_n) begin : modelProc
      logic x0;
      logic x1;
      logic acc;
      if (!reset_n) begin
         q0.delete();
         q1.delete();
         mCnt0 = 0;
         mCnt1 = 0;
      end else begin
         x0  = (q0.size() != 0) && bus.out0_ready;
         x1  = (q1.size() != 0) && bus.out1_ready;
         acc = bus.in_valid && modelInReady();
         if (x0) void'(q0.pop_front());
         if (x1) void'(q1.pop_front());
         if (acc) begin
            if (bus.in_sel) q1.push_back(bus.in_data);
            else            q0.push_back(bus.in_data);
         end
         if (cnt_clr) begin
            mCnt0 = 0;
            mCnt1 = 0;
         end else begin
            mCnt0 = (mCnt0 + int'(x0)) % CNT_MOD;
            mCnt1 = (mCnt1 + int'(x1)) % CNT_MOD;
         end
      end
   end

   // Every cycle out of reset, the DUT must agree with the model.
   always @(negedge clk) begin
      if (reset_n) begin
         checkOutput("m_in_ready", 32'(bus.in_ready), 32'(modelInReady()));
         checkOutput("m_out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
         checkOutput("m_out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
         if (q0.size() != 0) checkOutput("m_out0_data", 32'(bus.out0_data), 32'(q0[0]));
         if (q1.size() != 0) checkOutput("m_out1_data", 32'(bus.out1_data), 32'(q1[0]));
         checkOutput("m_cnt0", 32'(cnt0), 32'(mCnt0));
         checkOutput("m_cnt1", 32'(cnt1), 32'(mCnt1));
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      int accepted;
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      applyStimulus(0, 0, 8'h00, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      checkOutput("rst_out0_valid", 32'(bus.out0_valid), 32'h0);
      checkOutput("rst_out0_data", 32'(bus.out0_data), 32'h0);
      checkOutput("rst_out1_data", 32'(bus.out1_data), 32'h0);
      checkOutput("rst_cnt1", 32'(cnt1), 32'h0);

      $display("[TB] basic routing");
      applyStimulus(1, 1, 8'h3C, 1, 1, 0);
      checkOutput("route_in_ready", 32'(bus.in_ready), 32'h1);
      step();
      checkOutput("route_out1_valid", 32'(bus.out1_valid), 32'h1);
      checkOutput("route_out1_data", 32'(bus.out1_data), 32'h3C);
      checkOutput("route_out0_valid", 32'(bus.out0_valid), 32'h0);
      checkOutput("route_cnt1_pre", 32'(cnt1), 32'h0);
      applyStimulus(0, 0, 8'h00, 1, 1, 0);
      step();
      checkOutput("route_cnt1", 32'(cnt1), 32'h1);

      $display("[TB] back-pressure");
      applyStimulus(1, 0, 8'h11, 0, 1, 0);
      checkOutput("bp_first_ready", 32'(bus.in_ready), 32'h1);
      step();
      applyStimulus(1, 0, 8'h22, 0, 1, 0);
      checkOutput("bp_stall_ready", 32'(bus.in_ready), 32'h0);
      step();
      checkOutput("bp_hold_data", 32'(bus.out0_data), 32'h11);
      applyStimulus(1, 1, 8'h22, 0, 1, 0);
      checkOutput("bp_switch_ready", 32'(bus.in_ready), 32'h1);
      step();
      checkOutput("bp_out1_data", 32'(bus.out1_data), 32'h22);
      checkOutput("bp_out0_data", 32'(bus.out0_data), 32'h11);
      checkOutput("bp_out0_valid", 32'(bus.out0_valid), 32'h1);
      applyStimulus(0, 0, 8'h00, 1, 1, 0);
      step();

      $display("[TB] drain and refill");
      applyStimulus(0, 0, 8'h00, 1, 1, 1);
      step();
      applyStimulus(1, 0, 8'h01, 0, 1, 0);
      step();
      applyStimulus(1, 0, 8'h02, 1, 1, 0);
      checkOutput("refill_in_ready", 32'(bus.in_ready), 32'h1);
      step();
      checkOutput("refill_out0_valid", 32'(bus.out0_valid), 32'h1);
      checkOutput("refill_out0_data", 32'(bus.out0_data), 32'h02);
      checkOutput("refill_cnt0", 32'(cnt0), 32'h1);
      applyStimulus(0, 0, 8'h00, 1, 1, 0);
      step();
      checkOutput("refill_cnt0_after", 32'(cnt0), 32'h2);

      $display("[TB] throughput");
      applyStimulus(0, 0, 8'h00, 1, 1, 1);
      step();
      accepted = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, i[0], 8'(8'h40 + i), 1, 1, 0);
         if (bus.in_ready) accepted++;
         step();
      end
      applyStimulus(0, 0, 8'h00, 1, 1, 0);
      step();
      checkOutput("tput_accepted", 32'(accepted), 32'd20);
      checkOutput("tput_cnt0", 32'(cnt0), 32'd10);
      checkOutput("tput_cnt1", 32'(cnt1), 32'd10);

      $display("[TB] counter wrap and clear");
      applyStimulus(0, 0, 8'h00, 1, 1, 1);
      step();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 0, 8'(i), 1, 0, 0);
         step();
      end
      checkOutput("wrap_cnt0_15", 32'(cnt0), 32'd15);
      applyStimulus(0, 0, 8'h00, 1, 1, 0);
      step();
      checkOutput("wrap_cnt0_0", 32'(cnt0), 32'd0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 1, 8'(8'h60 + i), 1, 1, 0);
         step();
      end
      applyStimulus(0, 0, 8'h00, 1, 1, 0);
      step();
      checkOutput("clr_cnt1_5", 32'(cnt1), 32'd5);
      applyStimulus(1, 1, 8'h77, 1, 0, 0);
      step();
      applyStimulus(0, 0, 8'h00, 1, 1, 1);
      checkOutput("clr_out1_valid", 32'(bus.out1_valid), 32'h1);
      step();
      checkOutput("clr_cnt1_0", 32'(cnt1), 32'd0);
      checkOutput("clr_out1_drained", 32'(bus.out1_valid), 32'h0);

      $display("[TB] asynchronous reset mid-transfer");
      applyStimulus(1, 0, 8'h55, 1, 0, 0);
      step();
      applyStimulus(1, 0, 8'hA5, 1, 0, 0);
      step();
      applyStimulus(1, 0, 8'h00, 0, 0, 0);
      checkOutput("arst_pre_data", 32'(bus.out0_data), 32'hA5);
      checkOutput("arst_pre_cnt0", 32'(cnt0), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("arst_out0_valid", 32'(bus.out0_valid), 32'h0);
      checkOutput("arst_out0_data", 32'(bus.out0_data), 32'h0);
      checkOutput("arst_cnt0", 32'(cnt0), 32'h0);
      applyStimulus(0, 0, 8'h00, 1, 1, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();
      checkOutput("arst_after_valid", 32'(bus.out0_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_demux2_stream
